// File: rtl/branch_metric_frame_buffer.sv
// Ping-pong frame buffer feeding the alpha array: serially collects one trellis step per
// beat into a bank, presents full banks in fill order and holds them until released.
module branch_metric_frame_buffer #(
  parameter int unsigned BITS           = 16,
  parameter int unsigned SYMBOLS        = 10,
  parameter int unsigned OUTPUT_SYMBOLS = 4
) (
  input  logic                                             clk,
  input  logic                                             rst_n,
  input  logic                                             in_valid,
  output logic                                             in_ready,
  input  logic [OUTPUT_SYMBOLS-1:0][BITS-1:0]              in_metric,
  output logic                                             out_valid,
  output logic [SYMBOLS-1:0][OUTPUT_SYMBOLS-1:0][BITS-1:0] branch_metric,
  input  logic                                             frame_release,
  output logic [1:0]                                       occupancy,
  output logic                                             release_err
);

  localparam int unsigned CNT_W = (SYMBOLS > 1) ? $clog2(SYMBOLS) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(SYMBOLS - 1);

  typedef enum logic [1:0] {
    ST_EMPTY     = 2'd0,
    ST_FILLING   = 2'd1,
    ST_FULL      = 2'd2,
    ST_PRESENTED = 2'd3
  } bank_state_t;

  typedef logic [SYMBOLS-1:0][OUTPUT_SYMBOLS-1:0][BITS-1:0] frame_t;

  bank_state_t       r_state [2];
  bank_state_t       w_state_nxt [2];
  logic              r_wr_bank;
  logic              w_wr_bank_nxt;
  logic              r_rd_bank;
  logic              w_rd_bank_nxt;
  logic [CNT_W-1:0]  r_wr_cnt;
  logic [CNT_W-1:0]  w_wr_cnt_nxt;
  logic              r_out_valid;
  logic              w_out_valid_nxt;
  logic              r_release_err;
  logic              w_release_err_nxt;
  frame_t            r_bank [2];

  logic              w_accept;
  logic              w_any_presented;
  logic              w_present;
  logic              w_release;
  logic              w_last_step;

  // Writable bank is the one at wr_bank while it is still EMPTY or FILLING
  assign in_ready = rst_n && ((r_state[r_wr_bank] == ST_EMPTY) ||
                              (r_state[r_wr_bank] == ST_FILLING));

  assign w_accept        = in_valid && in_ready;
  assign w_last_step     = (r_wr_cnt == LAST_STEP);
  assign w_any_presented = (r_state[0] == ST_PRESENTED) || (r_state[1] == ST_PRESENTED);
  assign w_present       = !w_any_presented && (r_state[r_rd_bank] == ST_FULL);
  assign w_release       = frame_release && w_any_presented;

  // Next-state logic for both banks and the write/read pointers
  always_comb begin
    w_state_nxt[0]    = r_state[0];
    w_state_nxt[1]    = r_state[1];
    w_wr_bank_nxt     = r_wr_bank;
    w_rd_bank_nxt     = r_rd_bank;
    w_wr_cnt_nxt      = r_wr_cnt;
    w_out_valid_nxt   = 1'b0;
    w_release_err_nxt = r_release_err;

    if (w_accept) begin
      if (w_last_step) begin
        w_state_nxt[r_wr_bank] = ST_FULL;
        w_wr_cnt_nxt           = '0;
        w_wr_bank_nxt          = ~r_wr_bank;
      end else begin
        w_state_nxt[r_wr_bank] = ST_FILLING;
        w_wr_cnt_nxt           = r_wr_cnt + CNT_W'(1);
      end
    end

    // The presented bank is always rd_bank, and it can never be the bank being written
    if (w_release) begin
      w_state_nxt[r_rd_bank] = ST_EMPTY;
      w_rd_bank_nxt          = ~r_rd_bank;
    end

    // Present and release are mutually exclusive: one needs a PRESENTED bank, the other none
    if (w_present) begin
      w_state_nxt[r_rd_bank] = ST_PRESENTED;
      w_out_valid_nxt        = 1'b1;
    end

    if (frame_release && !w_any_presented) begin
      w_release_err_nxt = 1'b1;
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state[0]    <= ST_EMPTY;
      r_state[1]    <= ST_EMPTY;
      r_wr_bank     <= 1'b0;
      r_rd_bank     <= 1'b0;
      r_wr_cnt      <= '0;
      r_out_valid   <= 1'b0;
      r_release_err <= 1'b0;
    end else begin
      r_state[0]    <= w_state_nxt[0];
      r_state[1]    <= w_state_nxt[1];
      r_wr_bank     <= w_wr_bank_nxt;
      r_rd_bank     <= w_rd_bank_nxt;
      r_wr_cnt      <= w_wr_cnt_nxt;
      r_out_valid   <= w_out_valid_nxt;
      r_release_err <= w_release_err_nxt;
    end
  end

  // Frame storage; reset clears it so a discarded frame never leaks out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bank[0] <= '0;
      r_bank[1] <= '0;
    end else if (w_accept) begin
      r_bank[r_wr_bank][r_wr_cnt] <= in_metric;
    end
  end

  assign branch_metric = r_bank[r_rd_bank];
  assign out_valid     = r_out_valid;
  assign release_err   = r_release_err;
  assign occupancy     = 2'(r_state[0] != ST_EMPTY) + 2'(r_state[1] != ST_EMPTY);

endmodule

// File: tb/tb_branch_metric_frame_buffer.sv
// Randomized bench for branch_metric_frame_buffer against a frame-queue reference model.
module tb_branch_metric_frame_buffer;

  localparam int unsigned BITS    = 16;
  localparam int unsigned SYMBOLS = 10;
  localparam int unsigned OSYM    = 4;
  localparam int unsigned FW      = SYMBOLS * OSYM * BITS;

  typedef logic [OSYM-1:0][BITS-1:0]              step_t;
  typedef logic [SYMBOLS-1:0][OSYM-1:0][BITS-1:0] frame_t;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   in_valid = 1'b0;
  logic   in_ready;
  step_t  in_metric = '0;
  logic   out_valid;
  frame_t branch_metric;
  logic   frame_release = 1'b0;
  logic [1:0] occupancy;
  logic   release_err;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: completed frames in fill order, front one possibly presented
  frame_t m_full_q[$];
  step_t  m_cur_q[$];
  bit     m_presented = 0;
  bit     m_exp_ov = 0;
  bit     m_err = 0;
  int     m_released = 0;

  branch_metric_frame_buffer #(.BITS(BITS), .SYMBOLS(SYMBOLS), .OUTPUT_SYMBOLS(OSYM)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_metric     (in_metric),
    .out_valid     (out_valid),
    .branch_metric (branch_metric),
    .frame_release (frame_release),
    .occupancy     (occupancy),
    .release_err   (release_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic bit m_ready();
    return (rst_n == 1'b1) && (m_full_q.size() < 2);
  endfunction

  function automatic int m_occupancy();
    return m_full_q.size() + ((m_cur_q.size() > 0) ? 1 : 0);
  endfunction

  function automatic step_t rand_step();
    step_t s;
    for (int j = 0; j < OSYM; j++) s[j] = BITS'($urandom);
    return s;
  endfunction

  function automatic step_t tag_step(input int k);
    step_t s;
    for (int j = 0; j < OSYM; j++) s[j] = {8'(k), 8'(j)};
    return s;
  endfunction

  // One clock cycle: predict from model, advance both, compare
  task automatic tick(output bit acc);
    bit    pres;
    bit    rel;
    bit    rel_err;
    step_t d;
    frame_t f;
    check("in_ready", FW'(in_ready), FW'(m_ready()));
    acc     = in_valid && m_ready();
    pres    = !m_presented && (m_full_q.size() > 0);
    rel     = frame_release && m_presented;
    rel_err = frame_release && !m_presented;
    d       = in_metric;
    @(posedge clk);
    if (acc) begin
      m_cur_q.push_back(d);
      if (m_cur_q.size() == SYMBOLS) begin
        for (int k = 0; k < SYMBOLS; k++) f[k] = m_cur_q[k];
        m_full_q.push_back(f);
        m_cur_q.delete();
      end
    end
    if (rel) begin
      void'(m_full_q.pop_front());
      m_presented = 0;
      m_released++;
    end
    m_exp_ov = pres;
    if (pres) m_presented = 1;
    if (rel_err) m_err = 1;
    #1;
    check("out_valid", FW'(out_valid), FW'(m_exp_ov));
    check("occupancy", FW'(occupancy), FW'(m_occupancy()));
    check("release_err", FW'(release_err), FW'(m_err));
    if (m_presented) check("frame", FW'(branch_metric), FW'(m_full_q[0]));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    frame_release = 1'b0;
    #1;
    check("rst_out_valid", FW'(out_valid), FW'(0));
    check("rst_in_ready", FW'(in_ready), FW'(0));
    check("rst_occupancy", FW'(occupancy), FW'(0));
    check("rst_release_err", FW'(release_err), FW'(0));
    check("rst_frame", FW'(branch_metric), FW'(0));
    m_full_q.delete();
    m_cur_q.delete();
    m_presented = 0;
    m_exp_ov = 0;
    m_err = 0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send_step(input step_t d);
    bit acc;
    int budget;
    acc = 0;
    budget = 100;
    in_valid = 1'b1;
    in_metric = d;
    while (!acc && budget > 0) begin
      tick(acc);
      budget--;
    end
    if (!acc) check("send_timeout", FW'(0), FW'(1));
    in_valid = 1'b0;
  endtask

  task automatic wait_presented();
    bit acc;
    int budget;
    budget = 50;
    while (!m_presented && budget > 0) begin
      tick(acc);
      budget--;
    end
    check("present_timeout", FW'(m_presented), FW'(1));
  endtask

  task automatic pulse_release();
    bit acc;
    frame_release = 1'b1;
    tick(acc);
    frame_release = 1'b0;
  endtask

  // Random source gaps and random consumer release latency
  task automatic traffic(input int frames, input int vpct, input int rmin, input int rmax);
    bit acc;
    int target;
    int rel_wait;
    int budget;
    target = m_released + frames;
    rel_wait = -1;
    budget = frames * SYMBOLS * 20 + 200;
    while (m_released < target && budget > 0) begin
      if (!in_valid) begin
        in_valid = ($urandom_range(99) < vpct);
        in_metric = rand_step();
      end
      frame_release = (rel_wait == 0);
      tick(acc);
      if (acc) in_valid = 1'b0;
      if (frame_release) rel_wait = -1;
      else if (m_exp_ov) rel_wait = $urandom_range(rmax, rmin);
      else if (rel_wait > 0) rel_wait--;
      frame_release = 1'b0;
      budget--;
    end
    in_valid = 1'b0;
    check("traffic_done", FW'(m_released >= target), FW'(1));
  endtask

  initial begin
    bit acc;
    int ov_cnt;

    // Basic frame with tagged metrics, release 3 cycles after out_valid
    do_reset();
    for (int k = 0; k < SYMBOLS; k++) send_step(tag_step(k));
    wait_presented();
    check("t1_bm_3_2", FW'(branch_metric[3][2]), FW'(16'h0302));
    check("t1_bm_9_0", FW'(branch_metric[9][0]), FW'(16'h0900));
    for (int i = 0; i < 3; i++) tick(acc);
    pulse_release();
    tick(acc);

    // Three frames back-to-back with no release: buffer stalls after two
    do_reset();
    ov_cnt = 0;
    in_valid = 1'b1;
    in_metric = rand_step();
    for (int i = 0; i < 35; i++) begin
      tick(acc);
      if (out_valid) ov_cnt++;
      if (acc) in_metric = rand_step();
    end
    check("t2_ov_count", FW'(ov_cnt), FW'(1));
    check("t2_occupancy", FW'(occupancy), FW'(2));
    check("t2_in_ready", FW'(in_ready), FW'(0));
    pulse_release();
    tick(acc);
    check("t2_second_ov", FW'(out_valid), FW'(1));
    in_valid = 1'b0;

    // Release coinciding with the final-step accept of the other bank
    do_reset();
    for (int k = 0; k < SYMBOLS; k++) send_step(rand_step());
    for (int k = 0; k < SYMBOLS - 1; k++) send_step(rand_step());
    check("t4_presented", FW'(m_presented), FW'(1));
    in_valid = 1'b1;
    in_metric = rand_step();
    frame_release = 1'b1;
    tick(acc);
    check("t4_accepted", FW'(acc), FW'(1));
    frame_release = 1'b0;
    in_valid = 1'b0;
    tick(acc);
    check("t4_next_ov", FW'(out_valid), FW'(1));
    pulse_release();

    // Release with nothing presented sets a sticky error
    do_reset();
    pulse_release();
    tick(acc);
    check("t5_err", FW'(release_err), FW'(1));
    check("t5_occupancy", FW'(occupancy), FW'(0));
    for (int k = 0; k < SYMBOLS; k++) send_step(rand_step());
    wait_presented();
    pulse_release();
    check("t5_err_sticky", FW'(release_err), FW'(1));

    // Reset mid-frame and while presented, then a normal frame
    do_reset();
    for (int k = 0; k < 5; k++) send_step(rand_step());
    do_reset();
    for (int k = 0; k < SYMBOLS; k++) send_step(rand_step());
    wait_presented();
    do_reset();
    for (int k = 0; k < SYMBOLS; k++) send_step(tag_step(k + 16));
    wait_presented();
    check("t6_bm_0_1", FW'(branch_metric[0][1]), FW'(16'h1001));
    pulse_release();

    // Random traffic, 50 frames
    do_reset();
    traffic(50, 70, 0, 6);
    traffic(10, 100, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
